// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin mux arbiter.
// Optional lock feature elsewhere is controlled by MUX_ARB_LOCK_EN.
package mux_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  // FSM state encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SERVE = 1'b1;

  // Reset values
  localparam logic [SEL_W-1:0] PTR_RST   = '0;
  localparam state_t           STATE_RST = ST_IDLE;

  // Index to one-hot grant vector
  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle of the round-robin mux arbiter.
// The lock vector exists only when MUX_ARB_LOCK_EN is defined.
interface mux4_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned DW = 4
) ();

  logic [NREQ-1:0]  req;
  logic [DW-1:0]    d0;
  logic [DW-1:0]    d1;
  logic [DW-1:0]    d2;
  logic [DW-1:0]    d3;
`ifdef MUX_ARB_LOCK_EN
  logic [NREQ-1:0]  lock;
`endif
  logic [SEL_W-1:0] sel;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             busy;

`ifdef MUX_ARB_LOCK_EN
  // Producers and consumer side
  modport master (
    output req, d0, d1, d2, d3, lock, out_ready,
    input  sel, gnt, ack, out_valid, out_data, busy
  );
  // Arbiter side
  modport slave (
    input  req, d0, d1, d2, d3, lock, out_ready,
    output sel, gnt, ack, out_valid, out_data, busy
  );
`else
  // Producers and consumer side
  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  sel, gnt, ack, out_valid, out_data, busy
  );
  // Arbiter side
  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output sel, gnt, ack, out_valid, out_data, busy
  );
`endif

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Circular first-set-bit finder: scans cand_i from ptr_i upward, wrapping mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  cand_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest set bit wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_i[SEL_W'(ptr_i + SEL_W'(k))]) begin
        found_o = 1'b1;
        idx_o   = SEL_W'(ptr_i + SEL_W'(k));
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters, with a
// registered valid/ready output stage and a combinational per-requester ack.
// Define MUX_ARB_LOCK_EN to let a requester hold the grant for up to LOCK_MAX
// consecutive transfers.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DW       = 4,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux4_rr_arbiter_if.slave bus
);

  // Reject unsupported lock depths at elaboration
  if ((LOCK_MAX < 1) || (LOCK_MAX > 15)) begin : g_lock_max_bad
    $error("mux4_rr_arbiter: LOCK_MAX must be within 1..15");
  end

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;

  logic             hs_c;
  logic [NREQ-1:0]  cand_c;
  logic [SEL_W-1:0] pick_ptr_c;
  logic             found_c;
  logic [SEL_W-1:0] idx_c;
  logic             keep_c;
  logic [SEL_W-1:0] cap_sel_c;
  logic [DW-1:0]    cap_data_c;

`ifdef MUX_ARB_LOCK_EN
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);
  logic [3:0] cnt_q, cnt_d;
`endif

  assign hs_c = out_valid_q & bus.out_ready;

  // The granted requester is excluded at a handshake so it cannot win twice in a row
  assign cand_c = (state_q == ST_SERVE) ? (bus.req & ~gnt_q) : bus.req;

  // Scan from the pointer value that this handshake establishes
  assign pick_ptr_c = hs_c ? SEL_W'(sel_q + SEL_W'(1)) : ptr_q;

`ifdef MUX_ARB_LOCK_EN
  assign keep_c = hs_c & bus.lock[sel_q] & bus.req[sel_q] & (cnt_q < LOCK_LAST);
`else
  assign keep_c = 1'b0;
`endif

  assign cap_sel_c = keep_c ? sel_q : idx_c;

  rr_pick4 u_pick (
    .cand_i  (cand_c),
    .ptr_i   (pick_ptr_c),
    .found_o (found_c),
    .idx_o   (idx_c)
  );

  // Data capture mux
  always_comb begin
    cap_data_c = bus.d0;
    case (cap_sel_c)
      2'd0:    cap_data_c = bus.d0;
      2'd1:    cap_data_c = bus.d1;
      2'd2:    cap_data_c = bus.d2;
      default: cap_data_c = bus.d3;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef MUX_ARB_LOCK_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          state_d     = ST_SERVE;
          sel_d       = idx_c;
          gnt_d       = onehot(idx_c);
          out_valid_d = 1'b1;
          out_data_d  = cap_data_c;
        end
      end
      ST_SERVE: begin
        if (hs_c) begin
          if (keep_c) begin
            out_data_d = cap_data_c;
`ifdef MUX_ARB_LOCK_EN
            cnt_d      = cnt_q + 4'd1;
`endif
          end else begin
            ptr_d = SEL_W'(sel_q + SEL_W'(1));
`ifdef MUX_ARB_LOCK_EN
            cnt_d = 4'd0;
`endif
            if (found_c) begin
              sel_d       = idx_c;
              gnt_d       = onehot(idx_c);
              out_valid_d = 1'b1;
              out_data_d  = cap_data_c;
            end else begin
              state_d     = ST_IDLE;
              gnt_d       = '0;
              out_valid_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d     = STATE_RST;
        gnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_RST;
      ptr_q       <= PTR_RST;
      sel_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Consecutive locked-transfer counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q == ST_SERVE);
  assign bus.ack       = hs_c ? gnt_q : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed stimulus pushes the expected
// {grant, data} of each transfer; a monitor pops and checks at every handshake.
// Lock scenario runs only when MUX_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [3:0]    gnt;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  mux4_rr_arbiter_if #(.DW(DW)) bus ();

  mux4_rr_arbiter #(.DW(DW), .LOCK_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0001: return 2'd0;
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic [DW-1:0] dat);
    exp_t e;
    e.gnt  = g;
    e.data = dat;
    exp_q.push_back(e);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.d0        = '0;
    bus.d1        = '0;
    bus.d2        = '0;
    bus.d3        = '0;
    bus.out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    bus.lock      = '0;
`endif

    // Monitor: compare against the scoreboard at each handshake, ack must be idle otherwise
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_handshake: got gnt %0h with empty scoreboard at %0t",
                       bus.gnt, $time);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("mon_gnt",  32'(bus.gnt),      32'(e.gnt));
              check("mon_sel",  32'(bus.sel),      32'(idx_of(e.gnt)));
              check("mon_data", 32'(bus.out_data), 32'(e.data));
              check("mon_ack",  32'(bus.ack),      32'(e.gnt));
            end
          end else begin
            check("mon_ack_idle", 32'(bus.ack), 32'(0));
          end
        end
      end
    join_none

    // Reset state
    #2;
    check("rst_sel",   32'(bus.sel),       32'(0));
    check("rst_gnt",   32'(bus.gnt),       32'(0));
    check("rst_valid", 32'(bus.out_valid), 32'(0));
    check("rst_data",  32'(bus.out_data),  32'(0));
    check("rst_busy",  32'(bus.busy),      32'(0));
    check("rst_ack",   32'(bus.ack),       32'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    bus.req = 4'b0100; bus.d2 = 4'hA; bus.out_ready = 1'b1;
    push(4'b0100, 4'hA);
    tick();
    check("t1_gnt",   32'(bus.gnt),       32'(4'b0100));
    check("t1_valid", 32'(bus.out_valid), 32'(1));
    check("t1_busy",  32'(bus.busy),      32'(1));
    bus.req = 4'b0000;
    tick();
    check("t1_idle_valid", 32'(bus.out_valid), 32'(0));
    check("t1_idle_busy",  32'(bus.busy),      32'(0));
    check("t1_idle_gnt",   32'(bus.gnt),       32'(0));

    // Wrap-around: pointer sits at 3 after serving requester 2
    bus.req = 4'b1001; bus.d3 = 4'h5; bus.d0 = 4'h6;
    push(4'b1000, 4'h5);
    push(4'b0001, 4'h6);
    tick();
    check("t4_first", 32'(bus.gnt), 32'(4'b1000));
    bus.req = 4'b0001;
    tick();
    check("t4_second", 32'(bus.gnt), 32'(4'b0001));
    bus.req = 4'b0000;
    tick();
    check("t4_idle", 32'(bus.out_valid), 32'(0));

    // Reset while serving requester 3 with the consumer stalled
    bus.out_ready = 1'b0;
    bus.req = 4'b1000;
    tick();
    check("t5_pre_gnt",   32'(bus.gnt),       32'(4'b1000));
    check("t5_pre_valid", 32'(bus.out_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt",   32'(bus.gnt),       32'(0));
    check("t5_rst_valid", 32'(bus.out_valid), 32'(0));
    check("t5_rst_data",  32'(bus.out_data),  32'(0));
    check("t5_rst_sel",   32'(bus.sel),       32'(0));
    check("t5_rst_busy",  32'(bus.busy),      32'(0));
    check("t5_rst_ack",   32'(bus.ack),       32'(0));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    push(4'b1000, 4'h5);
    tick();
    check("t5_regrant", 32'(bus.gnt), 32'(4'b1000));
    bus.req = 4'b0000;
    tick();

    // Full rotation with all requesters held
    bus.d0 = 4'd1; bus.d1 = 4'd2; bus.d2 = 4'd3; bus.d3 = 4'd4;
    bus.req = 4'hF;
    push(4'b0001, 4'd1);
    push(4'b0010, 4'd2);
    push(4'b0100, 4'd3);
    push(4'b1000, 4'd4);
    push(4'b0001, 4'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.req = 4'b0000;
    tick();
    check("t2_idle", 32'(bus.out_valid), 32'(0));

    // Backpressure: captured word must hold while data input moves
    bus.out_ready = 1'b0;
    bus.req = 4'b0010; bus.d1 = 4'd3;
    push(4'b0010, 4'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_data",  32'(bus.out_data),  32'(3));
      check("t3_valid", 32'(bus.out_valid), 32'(1));
      check("t3_ack",   32'(bus.ack),       32'(0));
      if (i == 1) bus.d1 = 4'd7;
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t3_ack_release", 32'(bus.ack), 32'(4'b0010));
    tick();
    bus.req = 4'b0000;
    tick();

`ifdef MUX_ARB_LOCK_EN
    // Lock: requester 0 keeps the grant for LOCK_MAX transfers, then rotation resumes
    bus.d0 = 4'h9; bus.d1 = 4'hC;
    bus.req = 4'b0011; bus.lock = 4'b0001;
    for (int i = 0; i < 4; i++) push(4'b0001, 4'h9);
    push(4'b0010, 4'hC);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_locked_gnt", 32'(bus.gnt), 32'(4'b0001));
    end
    bus.req = 4'b0010;
    tick();
    check("t6_rotated_gnt", 32'(bus.gnt), 32'(4'b0010));
    bus.req = 4'b0000; bus.lock = 4'b0000;
    tick();
`endif

    // Every expected transfer must have been observed
    tick();
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
